// File: rtl/pc_predict_if.sv
// Fetch-side bus of pc_predict: fetch, resolve and jump inputs plus the
// fetch PC, link value, prediction, flush and mispredict counter outputs.
interface pc_predict_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [15:0]      inst;
    logic             res_valid;
    logic [WIDTH-1:0] res_pc;
    logic             res_taken;
    logic             res_pred_taken;
    logic [WIDTH-1:0] res_target;
    logic             jr_valid;
    logic [WIDTH-1:0] jr_target;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] pc_nx;
    logic             pred_taken;
    logic             flush;
    logic [15:0]      mispredict_cnt;

    modport master (
        output en, inst, res_valid, res_pc, res_taken, res_pred_taken,
               res_target, jr_valid, jr_target,
        input  fetch_pc, pc_nx, pred_taken, flush, mispredict_cnt
    );

    modport slave (
        input  en, inst, res_valid, res_pc, res_taken, res_pred_taken,
               res_target, jr_valid, jr_target,
        output fetch_pc, pc_nx, pred_taken, flush, mispredict_cnt
    );
endinterface

// File: rtl/pc_predict.sv
// Fetch PC with a direct-mapped table of 2-bit saturating branch counters,
// trained from execute and redirected on mispredicts and register jumps.
module pc_predict #(
    parameter int               WIDTH     = 16,
    parameter int               BHT_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int               INC       = 2
) (
    input  logic        clk,
    input  logic        rst,
    pc_predict_if.slave bus
);
    localparam int               IDX       = $clog2(BHT_DEPTH);
    localparam logic [WIDTH-1:0] INC_W     = WIDTH'(INC);
    localparam logic [1:0]       CTR_RESET = 2'b01;

    logic [1:0]       r_bht [BHT_DEPTH];
    logic [WIDTH-1:0] r_fetch_pc;
    logic [15:0]      r_mispredict_cnt;

    logic             w_is_branch;
    logic [IDX-1:0]   w_fetch_idx;
    logic [IDX-1:0]   w_res_idx;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_upd;
    logic             w_pred_taken;
    logic             w_mispredict;
    logic [WIDTH-1:0] w_pc_nx;
    logic [WIDTH-1:0] w_pred_target;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_unused_inst;

    // Opcodes 01100..01111 share the prefix 011.
    assign w_is_branch   = (bus.inst[15:13] == 3'b011);
    assign w_unused_inst = &{1'b0, bus.inst[10:8]};

    assign w_fetch_idx   = r_fetch_pc[IDX:1];
    assign w_res_idx     = bus.res_pc[IDX:1];
    assign w_ctr_cur     = r_bht[w_res_idx];

    assign w_pred_taken  = w_is_branch & r_bht[w_fetch_idx][1];
    assign w_pc_nx       = r_fetch_pc + INC_W;
    assign w_pred_target = w_pc_nx + {{(WIDTH-8){bus.inst[7]}}, bus.inst[7:0]};
    assign w_mispredict  = bus.res_valid & (bus.res_taken != bus.res_pred_taken);

    always_comb begin
        // NOTE: default assignment first so no path leaves w_next_pc unassigned (no latch).
        w_next_pc = w_pc_nx;
        if (w_mispredict)
            w_next_pc = bus.res_taken ? bus.res_target : (bus.res_pc + INC_W);
        else if (bus.jr_valid)
            w_next_pc = bus.jr_target;
        else if (!bus.en)
            w_next_pc = r_fetch_pc;
        else if (w_pred_taken)
            w_next_pc = w_pred_target;
    end

    always_comb begin
        w_ctr_upd = w_ctr_cur;
        if (bus.res_taken) begin
            if (w_ctr_cur != 2'b11) w_ctr_upd = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_upd = w_ctr_cur - 2'b01;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_fetch_pc <= RESET_PC;
        else      r_fetch_pc <= w_next_pc;
    end

    // NOTE: the table must be reset to weak not-taken, so it is built from resettable flops, not RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= CTR_RESET;
        end else if (bus.res_valid) begin
            r_bht[w_res_idx] <= w_ctr_upd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_mispredict_cnt <= '0;
        else if (w_mispredict && (r_mispredict_cnt != 16'hFFFF))
            r_mispredict_cnt <= r_mispredict_cnt + 16'd1;
    end

    assign bus.fetch_pc       = r_fetch_pc;
    assign bus.pc_nx          = w_pc_nx;
    assign bus.pred_taken     = w_pred_taken;
    assign bus.flush          = w_mispredict | bus.jr_valid;
    assign bus.mispredict_cnt = r_mispredict_cnt;
endmodule

// File: tb/tb_pc_predict.sv
// Directed bench for pc_predict: sequential fetch, prediction training,
// redirects, saturation, wrap-around and asynchronous reset.
module tb_pc_predict;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pc_predict_if #(.WIDTH(16)) bus ();

    pc_predict #(
        .WIDTH     (16),
        .BHT_DEPTH (16),
        .RESET_PC  (16'h0000),
        .INC       (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.en             = 1'b1;
        bus.inst           = 16'h0800;
        bus.res_valid      = 1'b0;
        bus.res_pc         = 16'h0000;
        bus.res_taken      = 1'b0;
        bus.res_pred_taken = 1'b0;
        bus.res_target     = 16'h0000;
        bus.jr_valid       = 1'b0;
        bus.jr_target      = 16'h0000;
    endtask

    task automatic jump_to(input logic [15:0] target);
        bus.jr_valid  = 1'b1;
        bus.jr_target = target;
        step();
        bus.jr_valid  = 1'b0;
    endtask

    task automatic resolve(input logic [15:0] pc, input logic taken);
        bus.res_valid      = 1'b1;
        bus.res_pc         = pc;
        bus.res_taken      = taken;
        bus.res_pred_taken = taken;
        step();
        bus.res_valid      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        bus.inst = 16'h6105;
        #1;
        checks++; if (bus.fetch_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc actual=%h expected=0000", bus.fetch_pc); end
        checks++; if (bus.pc_nx !== 16'h0002) begin errors++; $display("FAIL reset_pc_nx actual=%h expected=0002", bus.pc_nx); end
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred actual=%b expected=0", bus.pred_taken); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL reset_flush actual=%b expected=0", bus.flush); end
        checks++; if (bus.mispredict_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt actual=%h expected=0000", bus.mispredict_cnt); end
        @(negedge clk);
        rst = 1'b1;
        bus.inst = 16'h0800;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (bus.fetch_pc !== 16'(2 * i)) begin errors++; $display("FAIL seq_pc%0d actual=%h expected=%h", i, bus.fetch_pc, 16'(2 * i)); end
            checks++; if (bus.pred_taken !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL seq_ctl%0d actual=%b%b expected=00", i, bus.pred_taken, bus.flush); end
        end
    endtask

    task automatic test_predict();
        // Jump to 0x0010 while the first taken resolve trains its entry.
        bus.jr_valid = 1'b1; bus.jr_target = 16'h0010;
        bus.res_valid = 1'b1; bus.res_pc = 16'h0010; bus.res_taken = 1'b1; bus.res_pred_taken = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL jr_flush actual=%b expected=1", bus.flush); end
        step();
        checks++; if (bus.fetch_pc !== 16'h0010) begin errors++; $display("FAIL jr_pc actual=%h expected=0010", bus.fetch_pc); end
        bus.jr_valid = 1'b0; bus.en = 1'b0; bus.inst = 16'h6105;
        #1;
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL pred_weak actual=%b expected=1", bus.pred_taken); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL correct_noflush actual=%b expected=0", bus.flush); end
        step();
        checks++; if (bus.fetch_pc !== 16'h0010) begin errors++; $display("FAIL stall_pc actual=%h expected=0010", bus.fetch_pc); end
        bus.res_valid = 1'b0; bus.en = 1'b1;
        step();
        checks++; if (bus.fetch_pc !== 16'h0017) begin errors++; $display("FAIL pred_fwd actual=%h expected=0017", bus.fetch_pc); end
        bus.inst = 16'h0800;
        jump_to(16'h0010);
        bus.inst = 16'h61FC;
        #1;
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL pred_strong actual=%b expected=1", bus.pred_taken); end
        step();
        checks++; if (bus.fetch_pc !== 16'h000E) begin errors++; $display("FAIL pred_back actual=%h expected=000e", bus.fetch_pc); end
        clear_inputs();
    endtask

    task automatic test_mispredict();
        bus.en = 1'b0;
        bus.res_valid = 1'b1; bus.res_pc = 16'h0020; bus.res_taken = 1'b0; bus.res_pred_taken = 1'b1;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL mis_flush actual=%b expected=1", bus.flush); end
        step();
        checks++; if (bus.fetch_pc !== 16'h0022) begin errors++; $display("FAIL mis_pc actual=%h expected=0022", bus.fetch_pc); end
        checks++; if (bus.mispredict_cnt !== 16'd1) begin errors++; $display("FAIL mis_cnt actual=%0d expected=1", bus.mispredict_cnt); end
        clear_inputs();
    endtask

    task automatic test_priority();
        bus.jr_valid = 1'b1; bus.jr_target = 16'h0100;
        bus.res_valid = 1'b1; bus.res_pc = 16'h0032; bus.res_taken = 1'b1;
        bus.res_pred_taken = 1'b0; bus.res_target = 16'h0040;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL prio_flush actual=%b expected=1", bus.flush); end
        step();
        checks++; if (bus.fetch_pc !== 16'h0040) begin errors++; $display("FAIL prio_pc actual=%h expected=0040", bus.fetch_pc); end
        checks++; if (bus.mispredict_cnt !== 16'd2) begin errors++; $display("FAIL prio_cnt actual=%0d expected=2", bus.mispredict_cnt); end
        clear_inputs();
    endtask

    task automatic test_stall_read_before_write();
        // Entry for 0x0012 shares index 9 with 0x0032 and now holds 10.
        bus.en = 1'b0;
        jump_to(16'h0012);
        bus.inst = 16'h6105;
        bus.res_valid = 1'b1; bus.res_pc = 16'h0012; bus.res_taken = 1'b0; bus.res_pred_taken = 1'b0;
        #1;
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL rbw_old actual=%b expected=1", bus.pred_taken); end
        step();
        bus.res_valid = 1'b0;
        #1;
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL rbw_new actual=%b expected=0", bus.pred_taken); end
        checks++; if (bus.fetch_pc !== 16'h0012) begin errors++; $display("FAIL rbw_stall actual=%h expected=0012", bus.fetch_pc); end
        clear_inputs();
    endtask

    task automatic test_saturation();
        bus.en = 1'b0;
        jump_to(16'h0014);
        bus.inst = 16'h6105;
        for (int i = 0; i < 5; i++) resolve(16'h0014, 1'b0);
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL sat_low5 actual=%b expected=0", bus.pred_taken); end
        resolve(16'h0014, 1'b0);
        resolve(16'h0014, 1'b1);
        resolve(16'h0014, 1'b1);
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_low_up actual=%b expected=1", bus.pred_taken); end
        checks++; if (bus.fetch_pc !== 16'h0014) begin errors++; $display("FAIL sat_stall actual=%h expected=0014", bus.fetch_pc); end
        // Entry for 0x0010 is at 11; two more taken must not wrap it.
        jump_to(16'h0010);
        resolve(16'h0010, 1'b1);
        resolve(16'h0010, 1'b1);
        resolve(16'h0010, 1'b0);
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL sat_high actual=%b expected=1", bus.pred_taken); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        jump_to(16'hFFFE);
        checks++; if (bus.pc_nx !== 16'h0000) begin errors++; $display("FAIL wrap_pc_nx actual=%h expected=0000", bus.pc_nx); end
        step();
        checks++; if (bus.fetch_pc !== 16'h0000) begin errors++; $display("FAIL wrap_seq actual=%h expected=0000", bus.fetch_pc); end
        jump_to(16'hFFF0);
        bus.inst = 16'h6110;
        #1;
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL wrap_pred actual=%b expected=1", bus.pred_taken); end
        step();
        checks++; if (bus.fetch_pc !== 16'h0002) begin errors++; $display("FAIL wrap_target actual=%h expected=0002", bus.fetch_pc); end
        clear_inputs();
    endtask

    task automatic test_cnt_saturation();
        bus.en = 1'b0;
        bus.res_valid = 1'b1; bus.res_pc = 16'h0020; bus.res_taken = 1'b1;
        bus.res_pred_taken = 1'b0; bus.res_target = 16'h0040;
        step();
        checks++; if (bus.mispredict_cnt !== 16'd3) begin errors++; $display("FAIL cnt_inc actual=%0d expected=3", bus.mispredict_cnt); end
        for (int i = 1; i < 65536; i++) step();
        checks++; if (bus.mispredict_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat actual=%h expected=ffff", bus.mispredict_cnt); end
        checks++; if (bus.fetch_pc !== 16'h0040) begin errors++; $display("FAIL cnt_pc actual=%h expected=0040", bus.fetch_pc); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        // Index 0 was trained to 11 above, so a branch at 0x0040 predicts taken.
        bus.en = 1'b0;
        bus.inst = 16'h6105;
        #1;
        checks++; if (bus.pred_taken !== 1'b1) begin errors++; $display("FAIL pre_rst_pred actual=%b expected=1", bus.pred_taken); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (bus.fetch_pc !== 16'h0000) begin errors++; $display("FAIL arst_pc actual=%h expected=0000", bus.fetch_pc); end
        checks++; if (bus.pred_taken !== 1'b0) begin errors++; $display("FAIL arst_pred actual=%b expected=0", bus.pred_taken); end
        checks++; if (bus.mispredict_cnt !== 16'h0000) begin errors++; $display("FAIL arst_cnt actual=%h expected=0000", bus.mispredict_cnt); end
        checks++; if (bus.pc_nx !== 16'h0002) begin errors++; $display("FAIL arst_pc_nx actual=%h expected=0002", bus.pc_nx); end
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        step();
        checks++; if (bus.fetch_pc !== 16'h0002) begin errors++; $display("FAIL post_rst_pc actual=%h expected=0002", bus.fetch_pc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_predict();
        test_mispredict();
        test_priority();
        test_stall_read_before_write();
        test_saturation();
        test_wrap();
        test_cnt_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_predict.md
# pc_predict

Parametrised fetch-stage program counter with dynamic branch prediction. The block is the successor to the single-cycle PC unit. It holds the fetch PC and predicts conditional branches at fetch with a direct-mapped table of 2-bit saturating counters. It updates that table from resolved branches in execute, and redirects fetch on mispredicts and register jumps. It sits between instruction memory and the IF/ID pipeline register. It drives the flush that the hazard unit fans out to IF/ID and ID/EX.

## Interface
Parameters:
- WIDTH, 16, datapath/PC width in bits (≥ 9)
- BHT_DEPTH, 16, counter-table entries; power of 2, 2..256
- RESET_PC, 0, fetch PC after reset
- INC, 2, sequential PC increment in bytes

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- en  in  1  fetch enable; 0 = stall (hold PC)
- inst  in  16  instruction currently fetched at fetch_pc
- res_valid  in  1  execute resolves a conditional branch this cycle
- res_pc  in  WIDTH  PC of the resolving branch
- res_taken  in  1  actual outcome
- res_pred_taken  in  1  prediction carried down the pipe with that branch
- res_target  in  WIDTH  actual taken target
- jr_valid  in  1  register-indirect jump resolved in decode
- jr_target  in  WIDTH  its target
- fetch_pc  out  WIDTH  current fetch address
- pc_nx  out  WIDTH  fetch_pc + INC (link value)
- pred_taken  out  1  prediction for the instruction at fetch_pc
- flush  out  1  squash younger instructions this cycle
- mispredict_cnt  out  16  saturating mispredict count

## Operation
- A conditional branch is an instruction whose inst[15:11] is 01100, 01101, 01110 or 01111.
- Table index: fetch_pc[IDX:1] on read and res_pc[IDX:1] on write, where IDX = log2(BHT_DEPTH).
- Counter encoding:
  - 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken.
  - Prediction is counter[1].
- pred_taken = is_branch(inst) & counter[fetch index][1]. It is combinational.
- Predicted target = fetch_pc + INC + sign_extend(inst[7:0]). Arithmetic is modulo 2^WIDTH.
- mispredict = res_valid & (res_taken != res_pred_taken).
- Next-PC priority, highest first:
  1. mispredict: res_taken ? res_target : res_pc + INC. Applies regardless of en.
  2. jr_valid: jr_target. Applies regardless of en.
  3. en = 0: hold.
  4. pred_taken: predicted target.
  5. Otherwise: fetch_pc + INC.
- flush = mispredict | jr_valid. It is combinational.
- Table update: on res_valid, the indexed counter increments (taken) or decrements (not taken), saturating at 11 and 00. The update is independent of en.
- mispredict_cnt increments on each mispredict and saturates at 0xFFFF.
- Reset (rst = 0), immediate and asynchronous:
  - fetch_pc = RESET_PC.
  - All counters = 01.
  - mispredict_cnt = 0.
  - Resulting outputs: pc_nx = RESET_PC + INC, flush = 0 with no resolve/jump inputs.
  - pred_taken = 0, since counters are 01.

## Timing
- Redirect latency is 1 cycle: res_valid/jr_valid in cycle N gives fetch_pc = target in cycle N+1.
- Read/write same index in one cycle: the prediction uses the pre-update counter. The new value is visible the next cycle.
- Simultaneous mispredict and jr_valid: the mispredict wins, because the jump is older-path-squashed. The counter still updates and mispredict_cnt still increments.
- A correctly predicted resolve updates the counter only, with no flush and no redirect.
- Stall (en = 0) with no redirect: fetch_pc and pred_taken are stable; the table may still update.
- PC wrap: fetch_pc = 2^WIDTH − INC with sequential fetch gives fetch_pc = 0. A target overflow wraps silently.
- Reset deasserted mid-cycle: the first update happens at the first rising edge with rst = 1.

## Test plan
- Reset, en = 1, inst = 0x0800 (non-branch) for 3 cycles: fetch_pc goes 0x0000 → 0x0002 → 0x0004 → 0x0006, pred_taken = 0, flush = 0.
- inst = 0x6105 at fetch_pc 0x0010 after two taken resolves of res_pc 0x0010: counter 01 → 10 → 11, pred_taken = 1, next fetch_pc = 0x0017 (0x0010 + 2 + 5). With inst = 0x61FC instead: next fetch_pc = 0x000E.
- res_valid, res_pc = 0x0020, res_taken = 0, res_pred_taken = 1, en = 0: flush = 1 the same cycle, fetch_pc = 0x0022 next cycle, mispredict_cnt = 1.
- Same cycle jr_valid = 1 (jr_target = 0x0100) and a mispredict with res_taken = 1, res_target = 0x0040: fetch_pc = 0x0040.
- Saturation: five not-taken resolves at one index leave the counter at 00. Force 65536 mispredicts: mispredict_cnt = 0xFFFF.
- Assert rst mid-run at fetch_pc 0x0040: fetch_pc = RESET_PC without waiting for a clock edge, and all counters return to 01 (check pred_taken = 0 on a branch).
